proc_mem_arb: RTL and testbench

//  Shares one single-ported, variable-latency memory between the pipelined processor's

---
 rtl/proc_mem_arb_pkg.sv | 7 +
 rtl/proc_mem_arb_pick.sv | 17 +
 rtl/proc_mem_arb.sv | 89 ++++++++
 tb/tb_proc_mem_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_arb_pkg.sv
// proc_mem_arb_pkg: shared types for the processor memory arbiter
package proc_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {IMEM, DMEM} grant_t;
  localparam logic MEMREQ_READ = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;
endpackage

// File: rtl/proc_mem_arb_pick.sv
// proc_mem_arb_pick: winner select, fixed dmem priority or round-robin under PROC_MEM_ARB_RR_EN
module proc_mem_arb_pick
  import proc_mem_arb_pkg::*;
(
  input  logic   imem_val,
  input  logic   dmem_val,
`ifdef PROC_MEM_ARB_RR_EN
  input  grant_t last_grant,
`endif
  output grant_t win
);
`ifdef PROC_MEM_ARB_RR_EN
  always_comb win = (imem_val && dmem_val) ? (last_grant == IMEM ? DMEM : IMEM) : (imem_val ? IMEM : DMEM);
`else
  always_comb win = (imem_val && !dmem_val) ? IMEM : DMEM;
`endif
endmodule

// File: rtl/proc_mem_arb.sv
// proc_mem_arb: shares one memory between fetch and data ports; PROC_MEM_ARB_RR_EN enables round-robin
module proc_mem_arb
  import proc_mem_arb_pkg::*;
#(
  parameter int p_addr_w = 32,
  parameter int p_data_w = 32,
  parameter int p_timeout = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imemreq_val,
  input  logic [p_addr_w-1:0] imemreq_addr,
  output logic                imemresp_val,
  output logic [p_data_w-1:0] imemresp_data,
  input  logic                dmemreq_val,
  input  logic                dmemreq_type,
  input  logic [p_addr_w-1:0] dmemreq_addr,
  input  logic [p_data_w-1:0] dmemreq_wdata,
  output logic                dmemresp_val,
  output logic [p_data_w-1:0] dmemresp_rdata,
  output logic                memreq_val,
  input  logic                memreq_rdy,
  output logic                memreq_type,
  output logic [p_addr_w-1:0] memreq_addr,
  output logic [p_data_w-1:0] memreq_wdata,
  input  logic                memresp_val,
  input  logic [p_data_w-1:0] memresp_data,
  output logic                imem_stall,
  output logic                dmem_stall,
  output logic                err_timeout
);
  localparam int cnt_w = $clog2(p_timeout);
  state_t state, state_nxt;
  grant_t grant, win;
  logic [cnt_w-1:0] cnt;
  logic [p_data_w-1:0] resp_data;
  logic any_val, timeout;
  assign any_val = imemreq_val || dmemreq_val;
  assign timeout = cnt == cnt_w'(p_timeout - 1);
`ifdef PROC_MEM_ARB_RR_EN
  grant_t last_grant;
  always_ff @(posedge clk)
    if (!rst) last_grant <= IMEM;
    else if (state == IDLE && any_val) last_grant <= win;
  proc_mem_arb_pick u_pick (.imem_val(imemreq_val), .dmem_val(dmemreq_val), .last_grant(last_grant), .win(win));
`else
  proc_mem_arb_pick u_pick (.imem_val(imemreq_val), .dmem_val(dmemreq_val), .win(win));
`endif
  always_comb
    state_nxt = state == IDLE ? (any_val ? REQ : IDLE) :
                state == REQ  ? (memreq_rdy ? WAIT : REQ) :
                state == WAIT ? ((memresp_val || timeout) ? RESP : WAIT) : IDLE;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!rst) begin
      grant <= DMEM;
      memreq_type <= MEMREQ_READ;
      memreq_addr <= '0;
      memreq_wdata <= '0;
      resp_data <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && any_val) begin
        grant <= win;
        memreq_addr <= win == IMEM ? imemreq_addr : dmemreq_addr;
        memreq_type <= win == IMEM ? MEMREQ_READ : dmemreq_type;
        memreq_wdata <= win == IMEM ? '0 : dmemreq_wdata;
      end
      if (state == REQ) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + cnt_w'(1);
        if (memresp_val) resp_data <= memresp_data;
        else if (timeout) begin
          resp_data <= '0;
          err_timeout <= 1'b1;
        end
      end
    end
  assign memreq_val = state == REQ;
  assign imemresp_val = state == RESP && grant == IMEM;
  assign dmemresp_val = state == RESP && grant == DMEM;
  assign imemresp_data = resp_data;
  assign dmemresp_rdata = resp_data;
  assign imem_stall = imemreq_val && !imemresp_val;
  assign dmem_stall = dmemreq_val && !dmemresp_val;
endmodule

// File: tb/tb_proc_mem_arb.sv
// tb_proc_mem_arb: directed checks of proc_mem_arb (p_timeout=8), aware of PROC_MEM_ARB_RR_EN
module tb_proc_mem_arb;
  import proc_mem_arb_pkg::*;
  logic clk = 1'b0, rst;
  logic imemreq_val, imemresp_val, dmemreq_val, dmemreq_type, dmemresp_val;
  logic memreq_val, memreq_rdy, memreq_type, memresp_val;
  logic imem_stall, dmem_stall, err_timeout;
  logic [31:0] imemreq_addr, imemresp_data, dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
  logic [31:0] memreq_addr, memreq_wdata, memresp_data;
  int passed = 0, total = 0;

  proc_mem_arb #(.p_addr_w(32), .p_data_w(32), .p_timeout(8)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_val(dmemresp_val), .dmemresp_rdata(dmemresp_rdata),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_val(memresp_val), .memresp_data(memresp_data),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called in an IDLE cycle with the request already presented and memreq_rdy=1;
  // returns in the RESP cycle.
  task automatic serve(input string tag, input logic t, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic is_imem);
    tick();
    #1;
    chk({tag, "_req_val"}, memreq_val, 1);
    chk({tag, "_req_type"}, memreq_type, t);
    chk({tag, "_req_addr"}, memreq_addr, a);
    chk({tag, "_req_wdata"}, memreq_wdata, wd);
    tick();
    memresp_val = 1;
    memresp_data = rd;
    #1;
    chk({tag, "_wait_val"}, memreq_val, 0);
    tick();
    memresp_val = 0;
    #1;
    chk({tag, "_iresp"}, imemresp_val, is_imem);
    chk({tag, "_dresp"}, dmemresp_val, !is_imem);
    chk({tag, "_data"}, is_imem ? imemresp_data : dmemresp_rdata, rd);
  endtask

  initial begin
    rst = 0;
    imemreq_val = 0; imemreq_addr = 0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
    memreq_rdy = 0; memresp_val = 0; memresp_data = 0;
    tick(); tick();
    #1;
    chk("rst_memreq_val", memreq_val, 0);
    chk("rst_iresp", imemresp_val, 0);
    chk("rst_dresp", dmemresp_val, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_addr", memreq_addr, 0);
    chk("rst_rdata", dmemresp_rdata, 0);
    tick();
    rst = 1;
    // fetch with zero-wait memory
    imemreq_val = 1; imemreq_addr = 32'h100; memreq_rdy = 1;
    #1;
    chk("t1_stall", imem_stall, 1);
    chk("t1_idle_val", memreq_val, 0);
    serve("t1", MEMREQ_READ, 32'h100, 0, 32'h00A00093, 1);
    chk("t1_stall_rel", imem_stall, 0);
    tick();
    imemreq_val = 0;
    // simultaneous pair: dmem write first
    tick();
    imemreq_val = 1; imemreq_addr = 32'h300;
    dmemreq_val = 1; dmemreq_type = MEMREQ_WRITE; dmemreq_addr = 32'h200; dmemreq_wdata = 32'h55;
    #1;
    chk("t2_istall", imem_stall, 1);
    chk("t2_dstall", dmem_stall, 1);
    serve("t2d", MEMREQ_WRITE, 32'h200, 32'h55, 32'h1, 0);
    chk("t2_istall_hold", imem_stall, 1);
    tick();
    dmemreq_val = 0;
    serve("t2i", MEMREQ_READ, 32'h300, 0, 32'hBEEF, 1);
    tick();
    imemreq_val = 0;
    // second pair, then dmem re-presents while imem waits
    imemreq_val = 1; imemreq_addr = 32'h400;
    dmemreq_val = 1; dmemreq_type = MEMREQ_READ; dmemreq_addr = 32'h404; dmemreq_wdata = 0;
    serve("t3a", MEMREQ_READ, 32'h404, 0, 32'h11, 0);
    tick();
    dmemreq_addr = 32'h408;
`ifdef PROC_MEM_ARB_RR_EN
    serve("t3b", MEMREQ_READ, 32'h400, 0, 32'h22, 1);
    tick();
    imemreq_val = 0;
    serve("t3c", MEMREQ_READ, 32'h408, 0, 32'h33, 0);
    tick();
    dmemreq_val = 0;
`else
    serve("t3b", MEMREQ_READ, 32'h408, 0, 32'h33, 0);
    tick();
    dmemreq_val = 0;
    serve("t3c", MEMREQ_READ, 32'h400, 0, 32'h22, 1);
    tick();
    imemreq_val = 0;
`endif
    // memory holds off accept for 5 cycles
    memreq_rdy = 0;
    imemreq_val = 1; imemreq_addr = 32'h500;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_val", memreq_val, 1);
      chk("t4_addr", memreq_addr, 32'h500);
      chk("t4_type", memreq_type, MEMREQ_READ);
      chk("t4_stall", imem_stall, 1);
      tick();
    end
    memreq_rdy = 1;
    #1;
    chk("t4_accept_val", memreq_val, 1);
    tick();
    memresp_val = 1; memresp_data = 32'h77;
    tick();
    memresp_val = 0;
    #1;
    chk("t4_iresp", imemresp_val, 1);
    chk("t4_data", imemresp_data, 32'h77);
    tick();
    imemreq_val = 0;
    // timeout: no memory response
    dmemreq_val = 1; dmemreq_type = MEMREQ_READ; dmemreq_addr = 32'h600;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_err_pre", err_timeout, 0);
      chk("t5_dresp_pre", dmemresp_val, 0);
      chk("t5_dstall", dmem_stall, 1);
      tick();
    end
    #1;
    chk("t5_dresp", dmemresp_val, 1);
    chk("t5_data", dmemresp_rdata, 0);
    chk("t5_err", err_timeout, 1);
    tick();
    dmemreq_val = 0;
    #1;
    chk("t5_err_sticky", err_timeout, 1);
    chk("t5_dresp_off", dmemresp_val, 0);
    // reset during WAIT drops the late response
    tick();
    imemreq_val = 1; imemreq_addr = 32'h700;
    tick(); tick();
    rst = 0; imemreq_val = 0;
    tick();
    rst = 1; memresp_val = 1; memresp_data = 32'h1234;
    #1;
    chk("t6_memreq_val", memreq_val, 0);
    chk("t6_iresp", imemresp_val, 0);
    chk("t6_err_clr", err_timeout, 0);
    chk("t6_addr", memreq_addr, 0);
    tick();
    memresp_val = 0;
    #1;
    chk("t6_iresp2", imemresp_val, 0);
    chk("t6_dresp2", dmemresp_val, 0);
    chk("t6_data", imemresp_data, 0);
    chk("t6_memreq_val2", memreq_val, 0);
    imemreq_val = 1; imemreq_addr = 32'h800;
    serve("t6n", MEMREQ_READ, 32'h800, 0, 32'h99, 1);
    tick();
    imemreq_val = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
